dsc_con_cache_arb: RTL and testbench

//  Access controller for the DMA descriptor connection cache (4 x 13-bit two-port micro-RAM, registered read address and data).

---
 rtl/dsc_con_cache_arb.sv | 104 ++++++++++
 tb/tb_dsc_con_cache_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_con_cache_arb.sv
// Access controller for the DMA descriptor connection cache: write pass-through,
// round-robin read arbitration, per-entry valid tracking and a tagged response pipe.
module dsc_con_cache_arb #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_RD     = 2
) (
  input  logic                  CLK,
  input  logic                  SRST,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  inv_all,
  input  logic [NUM_RD-1:0]     rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [NUM_RD-1:0]     rd_gnt,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic                  rd_hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic                  mem_r_addr_en,
  output logic                  mem_r_data_en,
  output logic                  mem_srst_n,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]  valid_q;
  logic              rr_q;       // 0: requester 0 favoured
  logic              s1_valid_q;
  logic              s1_id_q;
  logic              s1_hit_q;
  logic [NUM_RD-1:0] eligible;
  logic [NUM_RD-1:0] gnt;
  logic              gnt_id;

  // A requester whose index is being written this cycle sits out one cycle so
  // the read never races the write inside the RAM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    eligible    = '0;
    eligible[0] = rd_req[0] & ~(wr_req & (rd_addr0 == wr_addr));
    eligible[1] = rd_req[1] & ~(wr_req & (rd_addr1 == wr_addr));
    gnt = '0;
    if (!SRST) begin
      if (!rr_q) begin
        if (eligible[0])      gnt = 2'b01;
        else if (eligible[1]) gnt = 2'b10;
      end else begin
        if (eligible[1])      gnt = 2'b10;
        else if (eligible[0]) gnt = 2'b01;
      end
    end
    gnt_id = gnt[1];
  end

  assign rd_gnt        = gnt;
  assign mem_r_addr    = gnt_id ? rd_addr1 : rd_addr0;
  assign mem_r_addr_en = |gnt;
  assign mem_r_data_en = s1_valid_q;
  assign mem_w_en      = wr_req & ~SRST;
  assign mem_w_addr    = wr_addr;
  assign mem_w_data    = wr_data;
  assign mem_srst_n    = ~SRST;
  assign rd_data       = mem_r_data;

  // Only the valid bits are reset; the RAM contents are meaningless until an
  // entry is written, which the valid bits already express.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (SRST) begin
      valid_q    <= '0;
      rr_q       <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_hit_q   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_id      <= 1'b0;
      rd_hit     <= 1'b0;
    end else begin
      if (inv_all)     valid_q <= '0;
      else if (wr_req) valid_q[wr_addr] <= 1'b1;

      if (|gnt) rr_q <= ~gnt_id;

      // Hit is sampled from the pre-edge valid bits, matching the data the
      // RAM address register captures at this same edge.
      s1_valid_q <= |gnt;
      s1_id_q    <= gnt_id;
      s1_hit_q   <= valid_q[mem_r_addr];
      rd_valid   <= s1_valid_q;
      rd_id      <= s1_id_q;
      rd_hit     <= s1_hit_q;
    end
  end

endmodule

// File: tb/tb_dsc_con_cache_arb.sv
// Self-checking bench for dsc_con_cache_arb: vector table for grants, a
// reference model with a response scoreboard, and a behavioural two-port RAM.
module tb_dsc_con_cache_arb;

  logic        CLK = 1'b0;
  logic        SRST;
  logic        wr_req;
  logic [1:0]  wr_addr;
  logic [12:0] wr_data;
  logic        inv_all;
  logic [1:0]  rd_req;
  logic [1:0]  rd_addr0;
  logic [1:0]  rd_addr1;
  logic [1:0]  rd_gnt;
  logic        rd_valid;
  logic        rd_id;
  logic        rd_hit;
  logic [12:0] rd_data;
  logic        mem_w_en;
  logic [1:0]  mem_w_addr;
  logic [12:0] mem_w_data;
  logic [1:0]  mem_r_addr;
  logic        mem_r_addr_en;
  logic        mem_r_data_en;
  logic        mem_srst_n;
  logic [12:0] mem_r_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  dsc_con_cache_arb dut (
    .CLK           (CLK),
    .SRST          (SRST),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .inv_all       (inv_all),
    .rd_req        (rd_req),
    .rd_addr0      (rd_addr0),
    .rd_addr1      (rd_addr1),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_id         (rd_id),
    .rd_hit        (rd_hit),
    .rd_data       (rd_data),
    .mem_w_en      (mem_w_en),
    .mem_w_addr    (mem_w_addr),
    .mem_w_data    (mem_w_data),
    .mem_r_addr    (mem_r_addr),
    .mem_r_addr_en (mem_r_addr_en),
    .mem_r_data_en (mem_r_data_en),
    .mem_srst_n    (mem_srst_n),
    .mem_r_data    (mem_r_data)
  );

  // Behavioural micro-RAM: registered read address and registered read data.
  logic [12:0] ram [4];
  logic [1:0]  ram_addr_q;
  logic [12:0] ram_data_q;
  initial for (int i = 0; i < 4; i++) ram[i] = '0;
  always @(posedge CLK) begin
    if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    if (!mem_srst_n) begin
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      if (mem_r_addr_en) ram_addr_q <= mem_r_addr;
      if (mem_r_data_en) ram_data_q <= ram[ram_addr_q];
    end
  end
  assign mem_r_data = ram_data_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and response scoreboard.
  typedef struct {
    logic        id;
    logic        hit;
    logic [1:0]  addr;
    logic [12:0] data;
    int          due;
  } resp_t;

  resp_t       sb [$];
  logic [3:0]  m_valid = '0;
  logic [12:0] m_mem [4];
  logic        m_rr = 1'b0;
  initial for (int i = 0; i < 4; i++) m_mem[i] = '0;

  always @(negedge CLK) begin
    logic [1:0] eg;
    logic [1:0] mg;
    logic       gid;
    logic [1:0] ga;
    resp_t      r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      check("rsp_valid", rd_valid, 1);
      check("rsp_id", rd_id, r.id);
      check("rsp_hit", rd_hit, r.hit);
      check("rsp_data", rd_data, r.data);
    end else begin
      check("rsp_idle", rd_valid, 0);
    end
    // The RAM captures data at the edge after the grant, before that edge's write.
    foreach (sb[i]) if (sb[i].due == cyc + 1) sb[i].data = m_mem[sb[i].addr];

    eg[0] = rd_req[0] && !(wr_req && rd_addr0 == wr_addr);
    eg[1] = rd_req[1] && !(wr_req && rd_addr1 == wr_addr);
    mg = 2'b00;
    if (!SRST) begin
      if (!m_rr) mg = eg[0] ? 2'b01 : (eg[1] ? 2'b10 : 2'b00);
      else       mg = eg[1] ? 2'b10 : (eg[0] ? 2'b01 : 2'b00);
    end
    check("gnt_model", rd_gnt, mg);
    check("mem_w_en", mem_w_en, wr_req && !SRST);
    check("mem_srst_n", mem_srst_n, !SRST);
    check("mem_r_addr_en", mem_r_addr_en, mg != 2'b00);
    if (mg != 2'b00) begin
      gid = mg[1];
      ga  = gid ? rd_addr1 : rd_addr0;
      check("mem_r_addr", mem_r_addr, ga);
      r.id = gid; r.hit = m_valid[ga]; r.addr = ga; r.data = '0; r.due = cyc + 2;
      sb.push_back(r);
    end

    if (SRST) begin
      m_valid = '0;
      m_rr    = 1'b0;
      sb.delete();
    end else begin
      if (inv_all)     m_valid = '0;
      else if (wr_req) m_valid[wr_addr] = 1'b1;
      if (wr_req) m_mem[wr_addr] = wr_data;
      if (mg != 2'b00) m_rr = ~mg[1];
    end
    cyc++;
  end

  typedef struct {
    logic        srst;
    logic        wr;
    logic [1:0]  wa;
    logic [12:0] wd;
    logic        inv;
    logic [1:0]  rq;
    logic [1:0]  a0;
    logic [1:0]  a1;
    logic [1:0]  gnt;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic srst, logic wr, logic [1:0] wa, logic [12:0] wd, logic inv,
                              logic [1:0] rq, logic [1:0] a0, logic [1:0] a1, logic [1:0] gnt);
    vec_t v;
    v.srst = srst; v.wr = wr; v.wa = wa; v.wd = wd; v.inv = inv;
    v.rq = rq; v.a0 = a0; v.a1 = a1; v.gnt = gnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    SRST = v.srst; wr_req = v.wr; wr_addr = v.wa; wr_data = v.wd; inv_all = v.inv;
    rd_req = v.rq; rd_addr0 = v.a0; rd_addr1 = v.a1;
  endtask

  initial begin
    vec_t v;
    //                srst wr wa  wd        inv rq     a0 a1 gnt
    vecs.push_back(mk(1, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00)); // reset
    vecs.push_back(mk(1, 1, 1, 13'h0005, 0, 2'b01, 2, 0, 2'b00)); // reset blocks write/grant
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b01, 2, 0, 2'b01)); // read idx2 -> miss
    vecs.push_back(mk(0, 1, 1, 13'h1ABC, 0, 2'b00, 0, 0, 2'b00)); // write idx1
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b01, 1, 0, 2'b01)); // read idx1 -> hit 1ABC
    vecs.push_back(mk(0, 1, 3, 13'h0333, 0, 2'b10, 0, 0, 2'b10)); // req1 moves rr back to 0
    vecs.push_back(mk(0, 1, 0, 13'h0AAA, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b11, 0, 3, 2'b01)); // alternating grants
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b11, 0, 3, 2'b10));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b11, 0, 3, 2'b01));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b11, 0, 3, 2'b10));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 2, 13'h1234, 0, 2'b01, 2, 0, 2'b00)); // collision blocks req0
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b01, 2, 0, 2'b01)); // granted, new data
    vecs.push_back(mk(0, 1, 3, 13'h0F0F, 0, 2'b11, 1, 3, 2'b01)); // req1 blocked only
    vecs.push_back(mk(0, 1, 1, 13'h1555, 0, 2'b00, 0, 0, 2'b00)); // write after grant -> old data
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 1, 0, 13'h0777, 1, 2'b00, 0, 0, 2'b00)); // write + inv -> invalid
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b01, 0, 0, 2'b01)); // read idx0 -> miss
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b10, 0, 1, 2'b10)); // grant, then reset
    vecs.push_back(mk(1, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00)); // no response here
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b01, 1, 0, 2'b01)); // valid bits cleared
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));
    vecs.push_back(mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00));

    drive(vecs[0]);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge CLK);
      check($sformatf("gnt_row%0d", i), rd_gnt, vecs[i].gnt);
      if (i == 2) check("reset_srst_n", mem_srst_n, 1);
      @(posedge CLK);
      #1;
    end

    // Mixed random traffic, checked entirely by the model.
    for (int n = 0; n < 80; n++) begin
      v = mk(0, 1'($urandom_range(0, 1)), 2'($urandom), 13'($urandom),
             ($urandom_range(0, 15) == 0), 2'($urandom), 2'($urandom), 2'($urandom), 2'b00);
      drive(v);
      @(negedge CLK);
      @(posedge CLK);
      #1;
    end

    v = mk(0, 0, 0, 13'h0000, 0, 2'b00, 0, 0, 2'b00);
    drive(v);
    for (int n = 0; n < 10 && sb.size() > 0; n++) begin
      @(posedge CLK);
      #1;
    end
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
